load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BUS_TIMEOUT, default 16: max cycles in WAIT before a load is faulted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  upstream (ALU result) operation valid.
REQ-005 in_ready  out  1  unit can accept an operation.
REQ-006 alu_res  in  Data  ALU output; memory address for LOAD/STORE, pass-through value otherwise.
REQ-007 store_data  in  Data  rs2 value for stores.
REQ-008 mem_op  in  MemOp  NONE / LOAD / STORE.
REQ-009 mem_size  in  MemSize  BYTE / HALF / WORD.
REQ-010 mem_unsigned  in  Bool  zero-extend loads when 1.
REQ-011 rd  in  5  destination register tag.
REQ-012 out_valid / out_ready  out / in  1  downstream (writeback) handshake.
REQ-013 out_data  out  Data;  out_rd  out  5;  out_fault  out  1 (misaligned or timeout).
REQ-014 bus_req, bus_we  out  1;  bus_addr  out  Data (bits[1:0]=0);  bus_wdata  out  Data;  bus_wstrb  out  4.
REQ-015 bus_gnt, bus_rvalid  in  1;  bus_rdata  in  Data.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept = in_valid & in_ready; on accept, alu_res, store_data, mem_op, mem_size, mem_unsigned, rd SHALL be registered.
REQ-018 IDLE->DONE on accept of NONE: out_data=alu_res, out_valid 1 cycle after accept.
REQ-019 Misalignment: HALF with addr[0]=1, WORD with addr[1:0]!=0; SHALL go IDLE->DONE, out_fault=1, out_data=0, no bus activity.
REQ-020 IDLE->REQ on accept of aligned LOAD/STORE; bus_req=1 exactly while in REQ.
REQ-021 In REQ: bus_addr={addr[31:2],2'b00}, bus_we=1 for STORE; on bus_gnt STORE->DONE, LOAD->WAIT.
REQ-022 bus_wdata: BYTE replicates byte 4x, HALF replicates halfword 2x, WORD as-is.
REQ-023 bus_wstrb: BYTE 0001<<off, HALF 0011<<off, WORD 1111, off=addr[1:0]; 0000 when bus_we=0.
REQ-024 bus_rvalid SHALL be ignored outside WAIT; earliest load completion is cycle after gnt.
REQ-025 In WAIT, on bus_rvalid: lane = bus_rdata >> (8*off); BYTE/HALF sign- or zero-extended per mem_unsigned; out_data captured; ->DONE.
REQ-026 WAIT cycle counter starts at 0 on entry; reaching BUS_TIMEOUT without rvalid SHALL go DONE with out_fault=1, out_data=0; late rvalid later ignored.
REQ-027 Simultaneous rvalid and timeout in same cycle: rvalid wins (no fault).
REQ-028 Stores: out_data=0, out_rd=0 (no writeback); loads/NONE: out_rd=registered rd.
REQ-029 DONE holds out_valid, out_data, out_rd, out_fault stable until out_ready; on out_ready ->IDLE.
REQ-030 No new operation accepted in the DONE->IDLE cycle (one bubble, no bypass).

Reset
REQ-031 On reset: state=IDLE, in_ready=0 during reset then 1, out_valid=0, out_data=0, out_rd=0, out_fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, counter=0.
REQ-032 Reset mid-transaction (REQ/WAIT/DONE) SHALL drop bus_req and out_valid asynchronously; outstanding response discarded.

Structure
REQ-033 MemOp, MemSize enums and Data/Bool typedefs SHALL live in the shared CPU package alongside ALUOp.
REQ-034 Load alignment/extension SHALL be a combinational sub-module load_align (rdata, off, size, unsigned -> Data).

Verification
REQ-035 NONE, alu_res=0x1234, out_ready=1 -> out_valid 1 cycle after accept, out_data=0x00001234, no bus_req.
REQ-036 STORE BYTE addr=0x103, store_data=0xAB, gnt after 2 cycles -> bus_addr=0x100, wstrb=1000, wdata=0xABABABAB, bus_req exactly 2 cycles.
REQ-037 LOAD BYTE signed addr=0x101, rdata=0x0000F000 -> out_data=0xFFFFFFF0; same with mem_unsigned=1 -> 0x000000F0.
REQ-038 LOAD WORD addr=0x102 -> out_fault=1, out_data=0, bus_req never asserted.
REQ-039 LOAD with no rvalid, BUS_TIMEOUT=16 -> out_fault=1 after 16 WAIT cycles; rvalid on cycle 16 instead -> no fault.
REQ-040 Reset asserted in WAIT, then out_ready held low in DONE -> bus_req=0, out_valid=0 immediately; DONE outputs stable for 5 cycles of back-pressure.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared CPU types: data/bool typedefs, ALU and memory-op enums, and store-lane helpers.
package load_store_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0] data_t;
    typedef logic            bool_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    // Size 3 is treated as a word everywhere.
    function automatic bool_t is_misaligned(logic [1:0] size, logic [1:0] off);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = off[0];
            default:   is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] store_strb(logic [1:0] size, logic [1:0] off);
        case (size)
            SIZE_BYTE: store_strb = STRB_W'(4'b0001 << off);
            SIZE_HALF: store_strb = STRB_W'(4'b0011 << off);
            default:   store_strb = 4'b1111;
        endcase
    endfunction

    function automatic data_t store_lanes(logic [1:0] size, data_t d);
        case (size)
            SIZE_BYTE: store_lanes = {4{d[7:0]}};
            SIZE_HALF: store_lanes = {2{d[15:0]}};
            default:   store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed lane out of a bus read word and sign/zero-extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] lane;

    assign lane = rdata >> {off, 3'b000};

    always_comb begin
        data = lane;
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            SIZE_HALF: data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            default:   data = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the ALU stage and writeback,
// with a request/grant memory bus, misalignment faults and a read timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_res,
    input  logic [31:0] store_data,
    input  logic [1:0]  mem_op,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e           state_q;
    logic             store_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic [RD_W-1:0]  rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             out_valid_q;
    data_t            out_data_q;
    logic [RD_W-1:0]  out_rd_q;
    logic             out_fault_q;
    logic             bus_req_q;
    logic             bus_we_q;
    data_t            bus_addr_q;
    data_t            bus_wdata_q;
    logic [STRB_W-1:0] bus_wstrb_q;

    mem_op_e          op_c;
    logic             is_mem_c;
    logic             is_store_c;
    data_t            load_data_c;

    assign op_c       = mem_op_e'(mem_op);
    assign is_store_c = (op_c == MEM_STORE);
    assign is_mem_c   = (op_c == MEM_LOAD) || is_store_c;

    load_align u_load_align (
        .rdata       (bus_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data_c)
    );

    // Reset is folded in so in_ready drops the instant reset rises.
    assign in_ready  = (state_q == S_IDLE) & ~reset;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_fault = out_fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rd_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_fault_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        store_q <= is_store_c;
                        size_q  <= mem_size;
                        uns_q   <= mem_unsigned;
                        off_q   <= alu_res[1:0];
                        rd_q    <= rd;
                        if (!is_mem_c) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= alu_res;
                            out_rd_q    <= rd;
                            out_fault_q <= 1'b0;
                        end else if (is_misaligned(mem_size, alu_res[1:0])) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_rd_q    <= is_store_c ? '0 : rd;
                            out_fault_q <= 1'b1;
                        end else begin
                            state_q     <= S_REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= is_store_c;
                            bus_addr_q  <= {alu_res[31:2], 2'b00};
                            bus_wdata_q <= is_store_c ? store_lanes(mem_size, store_data) : '0;
                            bus_wstrb_q <= is_store_c ? store_strb(mem_size, alu_res[1:0]) : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_wstrb_q <= '0;
                        if (store_q) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_rd_q    <= '0;
                            out_fault_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    // A response in the final counted cycle still beats the timeout.
                    if (bus_rvalid) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= load_data_c;
                        out_rd_q    <= rd_q;
                        out_fault_q <= 1'b0;
                    end else if (cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= '0;
                        out_rd_q    <= rd_q;
                        out_fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
